irq_trap_ctrl: RTL and testbench

- Interrupt sequencer that sits directly upstream of the CSR file in the multicycle OTTER.
- Synchronises and latches the external interrupt, then decides at instruction boundaries whether to take a trap. It gates the decision on the CSR mie/mstatus state.
- Emits the int_taken/int_ret pulses and the saved PC consumed by the CSR file.
- Supplies the fetch-stage PC redirect (mtvec on trap, mepc on mret).

---
 rtl/irq_trap_ctrl.sv | 143 ++++++++++++++
 tb/tb_irq_trap_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_trap_ctrl.sv
// ---------------------------------------------------------------------------
// irq_trap_ctrl
//
// Interrupt sequencer placed directly upstream of the CSR file in the
// multicycle OTTER core. It synchronises the external interrupt into the clk
// domain and latches it as "pending". At instruction boundaries (instr_done)
// it decides whether to take a trap, gating that decision on mie/mstatus.
// It also sequences MRET.
//
// While a trap or return is in progress, the block:
//   - pulses int_taken or int_ret towards the CSR file,
//   - redirects fetch to mtvec or mepc,
//   - stalls the multicycle FSM in fetch.
//
// Parameters
//   SYNC_STAGES  flops in the ext_irq synchroniser (legal range 2..4)
//   EDGE_TRIG    1 = pending latch set on a rising edge of the synchronised
//                irq; 0 = set whenever the synchronised irq is high
//   CNT_W        width of the taken-trap counter (wraps)
//
// Ports
//   clk             system clock, all state on posedge
//   rst             asynchronous active-low reset
//   ext_irq         external interrupt request (asynchronous to clk)
//   instr_done      multicycle FSM is in the writeback cycle of an instruction
//   mret_exec       completing instruction is MRET (qualified by instr_done)
//   next_pc         PC of next sequential instruction, valid with instr_done
//   mie, mstatus    CSR interrupt enable / global enable
//   mtvec, mepc     CSR trap vector / saved return PC
//   int_taken       one-cycle pulse: trap taken
//   int_ret         one-cycle pulse: return from trap
//   int_epc         PC to save into mepc, valid while int_taken=1
//   redirect_valid  fetch must load redirect_pc this cycle
//   redirect_pc     mtvec during a trap, mepc during a return, else 0
//   cpu_stall       multicycle FSM must hold in fetch
//   irq_pending     pending latch state
//   irq_count       number of traps taken
//   state_dbg       current sequencer state (0 IDLE, 1 TRAP, 2 RET)
//
// Handshake: redirect_valid has no ready. Fetch must accept redirect_pc in
// every cycle where redirect_valid=1. Each such cycle is a single-cycle,
// non-repeating command.
// ---------------------------------------------------------------------------
module irq_trap_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TRIG   = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ext_irq,
    input  logic             instr_done,
    input  logic             mret_exec,
    input  logic [31:0]      next_pc,
    input  logic             mie,
    input  logic             mstatus,
    input  logic [31:0]      mtvec,
    input  logic [31:0]      mepc,
    output logic             int_taken,
    output logic             int_ret,
    output logic [31:0]      int_epc,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             cpu_stall,
    output logic             irq_pending,
    output logic [CNT_W-1:0] irq_count,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRAP = 2'd1,
        RET  = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   irq_s;
    logic                   irq_s_d;
    logic                   pending;
    logic                   pend_set;
    logic                   take_trap;
    logic                   take_ret;

    assign irq_s = sync_q[SYNC_STAGES-1];

    // Edge mode needs one history flop beyond the synchroniser. Level mode
    // keeps re-setting the latch for as long as the request stays high.
    assign pend_set = (EDGE_TRIG != 0) ? (irq_s & ~irq_s_d) : irq_s;

    // MRET wins over a pending interrupt. The CSR re-enables mstatus on the
    // RET edge, so the interrupt is taken at the next qualifying boundary.
    assign take_ret  = instr_done & mret_exec;
    assign take_trap = instr_done & ~mret_exec & pending & mie & mstatus;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '0;
            irq_s_d   <= 1'b0;
            pending   <= 1'b0;
            irq_count <= '0;
            int_epc   <= 32'd0;
            state     <= IDLE;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], ext_irq};
            irq_s_d <= irq_s;

            // The clear happens in the int_taken cycle. A new set condition
            // in that same cycle takes priority over the clear.
            pending <= pend_set | (pending & (state != TRAP));

            if (state == TRAP) begin
                irq_count <= irq_count + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (take_ret) begin
                        state <= RET;
                    end else if (take_trap) begin
                        state   <= TRAP;
                        int_epc <= next_pc;
                    end
                end
                TRAP:    state <= IDLE;
                RET:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Moore outputs are decoded straight from the state register. Because of
    // this, an asynchronous reset drops them in the same instant.
    assign int_taken      = (state == TRAP);
    assign int_ret        = (state == RET);
    assign redirect_valid = (state == TRAP) || (state == RET);
    assign cpu_stall      = (state == TRAP) || (state == RET);
    assign redirect_pc    = (state == TRAP) ? mtvec :
                            (state == RET)  ? mepc  : 32'd0;
    assign irq_pending    = pending;
    assign state_dbg      = state;

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_trap_ctrl
//
// Runs two instances of irq_trap_ctrl from the same stimulus:
//   - u_edge: edge-triggered, 2 sync stages, 16-bit counter
//   - u_lvl:  level-sensitive, 3 sync stages, 3-bit counter (wraps quickly)
//
// A behavioural model tracks the following for each instance:
//   - sampled ext_irq history,
//   - the pending flag,
//   - the current phase (idle / trap / ret),
//   - the trap count.
// Every cycle, all outputs of both instances are compared with the model.
// Expected saved PCs go through a scoreboard queue. Directed scenarios are
// followed by randomised traffic.
// ---------------------------------------------------------------------------
module tb_irq_trap_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        ext_irq    = 1'b0;
    logic        instr_done = 1'b0;
    logic        mret_exec  = 1'b0;
    logic [31:0] next_pc    = 32'd0;
    logic        mie        = 1'b0;
    logic        mstatus    = 1'b0;
    logic [31:0] mtvec      = 32'd0;
    logic [31:0] mepc       = 32'd0;

    logic        it_e, ir_e, rv_e, cs_e, ip_e;
    logic [31:0] epc_e, rp_e;
    logic [15:0] cnt_e;
    logic [1:0]  st_e;
    logic        it_l, ir_l, rv_l, cs_l, ip_l;
    logic [31:0] epc_l, rp_l;
    logic [2:0]  cnt_l;
    logic [1:0]  st_l;

    irq_trap_ctrl #(.SYNC_STAGES(2), .EDGE_TRIG(1), .CNT_W(16)) u_edge (
        .clk(clk), .rst(rst), .ext_irq(ext_irq), .instr_done(instr_done),
        .mret_exec(mret_exec), .next_pc(next_pc), .mie(mie), .mstatus(mstatus),
        .mtvec(mtvec), .mepc(mepc), .int_taken(it_e), .int_ret(ir_e),
        .int_epc(epc_e), .redirect_valid(rv_e), .redirect_pc(rp_e),
        .cpu_stall(cs_e), .irq_pending(ip_e), .irq_count(cnt_e),
        .state_dbg(st_e)
    );

    irq_trap_ctrl #(.SYNC_STAGES(3), .EDGE_TRIG(0), .CNT_W(3)) u_lvl (
        .clk(clk), .rst(rst), .ext_irq(ext_irq), .instr_done(instr_done),
        .mret_exec(mret_exec), .next_pc(next_pc), .mie(mie), .mstatus(mstatus),
        .mtvec(mtvec), .mepc(mepc), .int_taken(it_l), .int_ret(ir_l),
        .int_epc(epc_l), .redirect_valid(rv_l), .redirect_pc(rp_l),
        .cpu_stall(cs_l), .irq_pending(ip_l), .irq_count(cnt_l),
        .state_dbg(st_l)
    );

    // ---------------- reference model ----------------
    localparam int PH_IDLE = 0;
    localparam int PH_TRAP = 1;
    localparam int PH_RET  = 2;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  hist [2];      // bit k = ext_irq sampled k+1 edges ago
    bit          m_pend [2];
    int          m_phase [2];
    int          m_cnt [2];
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            hist[i]    = 8'd0;
            m_pend[i]  = 1'b0;
            m_phase[i] = PH_IDLE;
            m_cnt[i]   = 0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // One clock edge of one instance, computed from the rules.
    // irq_s is the sample taken n edges ago; irq_s_d is the sample before it.
    task automatic model_step(input int i, input int n, input bit edge_mode,
                              input int cw);
        bit s, sd, set_c, nxt_pend;
        s        = hist[i][n-1];
        sd       = hist[i][n];
        set_c    = edge_mode ? (s && !sd) : s;
        nxt_pend = set_c || (m_pend[i] && m_phase[i] != PH_TRAP);
        if (m_phase[i] == PH_TRAP) m_cnt[i] = (m_cnt[i] + 1) % (1 << cw);
        if (m_phase[i] != PH_IDLE) begin
            m_phase[i] = PH_IDLE;
        end else if (instr_done && mret_exec) begin
            m_phase[i] = PH_RET;
        end else if (instr_done && m_pend[i] && mie && mstatus) begin
            m_phase[i] = PH_TRAP;
            if (i == 0) exp_q0.push_back(next_pc);
            else        exp_q1.push_back(next_pc);
        end
        m_pend[i] = nxt_pend;
        hist[i]   = {hist[i][6:0], ext_irq};
    endtask

    task automatic check_outs(input int i, input logic it, input logic ir,
                              input logic rv, input logic [31:0] rp,
                              input logic cs, input logic ip,
                              input logic [31:0] cnt, input logic [31:0] epc);
        string       p;
        logic [31:0] exp_rp;
        logic [31:0] exp_epc;
        p = (i == 0) ? "e_" : "l_";
        exp_rp = (m_phase[i] == PH_TRAP) ? mtvec :
                 (m_phase[i] == PH_RET)  ? mepc  : 32'd0;
        check_eq({p, "int_taken"},      32'(it), 32'(m_phase[i] == PH_TRAP));
        check_eq({p, "int_ret"},        32'(ir), 32'(m_phase[i] == PH_RET));
        check_eq({p, "redirect_valid"}, 32'(rv), 32'(m_phase[i] != PH_IDLE));
        check_eq({p, "cpu_stall"},      32'(cs), 32'(m_phase[i] != PH_IDLE));
        check_eq({p, "redirect_pc"},    rp, exp_rp);
        check_eq({p, "irq_pending"},    32'(ip), 32'(m_pend[i]));
        check_eq({p, "irq_count"},      cnt, 32'(m_cnt[i]));
        if (m_phase[i] == PH_TRAP) begin
            exp_epc = 32'hDEAD_BEEF;
            if (i == 0 && exp_q0.size() > 0) exp_epc = exp_q0.pop_front();
            if (i == 1 && exp_q1.size() > 0) exp_epc = exp_q1.pop_front();
            check_eq({p, "int_epc"}, epc, exp_epc);
        end
    endtask

    task automatic check_all();
        check_outs(0, it_e, ir_e, rv_e, rp_e, cs_e, ip_e, 32'(cnt_e), epc_e);
        check_outs(1, it_l, ir_l, rv_l, rp_l, cs_l, ip_l, 32'(cnt_l), epc_l);
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after posedge; outputs are checked there too.
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            model_step(0, 2, 1'b1, 16);
            model_step(1, 3, 1'b0, 3);
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic instr(input logic m, input logic [31:0] pc);
        instr_done = 1'b1;
        mret_exec  = m;
        next_pc    = pc;
        cycle();
        instr_done = 1'b0;
        mret_exec  = 1'b0;
    endtask

    // Asserts reset between clock edges, checks that everything dropped
    // asynchronously, holds for two edges, then releases.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_eq({tag, "_taken"}, 32'(it_e), 32'd0);
        check_eq({tag, "_rvalid"}, 32'(rv_e), 32'd0);
        check_eq({tag, "_count"}, 32'(cnt_e), 32'd0);
        check_eq({tag, "_epc"}, epc_e, 32'd0);
        check_all();
        idle(2);
        rst = 1'b1;
        cycle();
        check_eq({tag, "_state"}, 32'(st_e), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        idle(3);
        check_eq("rst_state", 32'(st_e), 32'd0);
        check_eq("rst_pending", 32'(ip_e), 32'd0);
        rst = 1'b1;
        cycle();
        check_eq("rel_taken", 32'(it_e), 32'd0);
        check_eq("rel_count", 32'(cnt_e), 32'd0);

        // Basic trap.
        mie = 1'b1; mstatus = 1'b1; mtvec = 32'h100; mepc = 32'h0;
        ext_irq = 1'b1;
        idle(6);
        instr(1'b0, 32'h2004);
        check_eq("basic_taken", 32'(it_e), 32'd1);
        check_eq("basic_epc", epc_e, 32'h2004);
        check_eq("basic_rpc", rp_e, 32'h100);
        check_eq("basic_stall", 32'(cs_e), 32'd1);
        ext_irq = 1'b0;
        cycle();
        check_eq("basic_pulse_end", 32'(it_e), 32'd0);
        check_eq("basic_count", 32'(cnt_e), 32'd1);
        check_eq("basic_pending", 32'(ip_e), 32'd0);
        idle(8);

        // Masked: pending holds over 20 instruction boundaries.
        mstatus = 1'b0;
        ext_irq = 1'b1; cycle(); ext_irq = 1'b0;
        idle(6);
        for (int k = 0; k < 20; k++) begin
            instr(1'b0, $urandom & 32'hFFFF_FFFC);
            check_eq("masked_no_trap", 32'(it_e), 32'd0);
            cycle();
        end
        check_eq("masked_pending", 32'(ip_e), 32'd1);
        mstatus = 1'b1;
        instr(1'b0, 32'h3000);
        check_eq("unmask_taken", 32'(it_e), 32'd1);
        check_eq("unmask_epc", epc_e, 32'h3000);
        idle(2);

        // MRET.
        mepc = 32'h2004;
        instr(1'b1, 32'h5000);
        check_eq("mret_ret", 32'(ir_e), 32'd1);
        check_eq("mret_rpc", rp_e, 32'h2004);
        check_eq("mret_taken", 32'(it_e), 32'd0);
        idle(2);

        // Collision: MRET at the same boundary as a pending interrupt.
        ext_irq = 1'b1; cycle(); ext_irq = 1'b0;
        idle(6);
        instr(1'b1, 32'h6000);
        check_eq("coll_ret", 32'(ir_e), 32'd1);
        check_eq("coll_no_trap", 32'(it_e), 32'd0);
        cycle();
        check_eq("coll_still_pend", 32'(ip_e), 32'd1);
        check_eq("coll_no_b2b", 32'(it_e), 32'd0);
        instr(1'b0, 32'h6004);
        check_eq("coll_trap", 32'(it_e), 32'd1);
        check_eq("coll_epc", epc_e, 32'h6004);
        idle(2);

        // Request held high for 100 cycles, starting from a clean reset.
        async_reset("rst_hold");
        ext_irq = 1'b1;
        for (int k = 0; k < 20; k++) begin
            idle(4);
            instr(1'b0, 32'h8000 + 32'(k * 4));
        end
        check_eq("hold_edge_once", 32'(cnt_e), 32'd1);
        check_eq("hold_lvl_repend", 32'(ip_l), 32'd1);
        ext_irq = 1'b0;
        idle(8);

        // Reset in the middle of a trap.
        ext_irq = 1'b1; cycle(); ext_irq = 1'b0;
        idle(6);
        instr(1'b0, 32'h7000);
        check_eq("midtrap_taken", 32'(it_e), 32'd1);
        async_reset("rst_midtrap");

        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(7) == 0) ext_irq = ~ext_irq;
            if ($urandom_range(15) == 0) mie = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) mstatus = ($urandom_range(3) != 0);
            if ($urandom_range(31) == 0) mtvec = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(31) == 0) mepc = $urandom & 32'hFFFF_FFFC;
            instr_done = ($urandom_range(3) == 0);
            mret_exec  = instr_done && ($urandom_range(4) == 0);
            next_pc    = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(999) == 0) begin
                instr_done = 1'b0;
                mret_exec  = 1'b0;
                async_reset("rst_rand");
            end else begin
                cycle();
            end
        end
        instr_done = 1'b0;
        mret_exec  = 1'b0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
